lk_list_writer: RTL and testbench
=================================

LK_LIST_WRITER -- requirements
Module: lk_list_writer

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 32, node value/memory word width; SHALL be >= ADDR_W.
REQ-003 Parameter BASE_ADDR, default 2, address of first node; SHALL be nonzero and even.
REQ-004 Parameter MAX_NODES, default 16, node capacity; SHALL satisfy BASE_ADDR+2*MAX_NODES <= 2^ADDR_W.
REQ-005 clk  input  1  rising-edge clock, the only clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 clr  input  1  synchronous restart: new empty list.
REQ-008 in_valid  input  1  in_data/in_last valid.
REQ-009 in_data  input  DATA_W  node value.
REQ-010 in_last  input  1  marks final node of list.
REQ-011 in_ready  output  1  block accepts a node this cycle.
REQ-012 mem_we  output  1  memory write strobe, one word per cycle.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  DATA_W  write data.
REQ-015 head  output  ADDR_W  list head pointer, 0 when list empty.
REQ-016 node_cnt  output  ADDR_W  nodes committed.
REQ-017 busy  output  1  node write in progress.
REQ-018 done  output  1  list terminated by in_last, held.
REQ-019 full  output  1  node_cnt == MAX_NODES.

Function
REQ-020 Node layout SHALL be: word at addr n = value, word at n+1 = next pointer zero-extended to DATA_W; next 0 = end of list (matches the traversal datapath's nonzero test).
REQ-021 FSM states SHALL be IDLE, WVAL, WNXT, PATCH, DONE.
REQ-022 in_ready SHALL be 1 only in IDLE with full=0.
REQ-023 Handshake: node accepted on a cycle where in_valid and in_ready are both 1; in_data/in_last latched; IDLE->WVAL.
REQ-024 WVAL: mem_we=1, mem_addr=cur, mem_wdata=latched value; ->WNXT.
REQ-025 WNXT: mem_we=1, mem_addr=cur+1, mem_wdata=0; ->PATCH if node_cnt>0, else commit.
REQ-026 PATCH: mem_we=1, mem_addr=prev+1, mem_wdata=cur; then commit.
REQ-027 Commit (same edge leaving WNXT/PATCH): prev<=cur, cur<=cur+2, node_cnt<=node_cnt+1, head<=BASE_ADDR if first node; ->DONE if latched in_last else IDLE.
REQ-028 Accept-to-commit latency: 2 cycles for the first node, 3 cycles otherwise; next accept earliest on the cycle after commit.
REQ-029 busy SHALL be 1 in WVAL, WNXT and PATCH only; mem_we SHALL be 0 in IDLE and DONE.
REQ-030 DONE: done=1, in_ready=0, remains until clr or rst.
REQ-031 full: in_ready=0 in IDLE; in_valid ignored; list remains valid (last next=0); no wrap-around of cur.
REQ-032 clr: in IDLE/DONE, next edge returns to IDLE with cur=BASE_ADDR, node_cnt=0, head=0, done=0; clr during busy states SHALL be deferred until commit, then applied.
REQ-033 clr and a valid handshake in the same IDLE cycle: clr wins, node not accepted (in_ready forced 0 while clr=1).
REQ-034 Memory contents SHALL never be read; list is always well-formed after each commit.

Reset
REQ-035 rst SHALL asynchronously force IDLE, cur=BASE_ADDR, prev=0, head=0, node_cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, busy=0, full=0; in_ready=1 after rst deasserts.
REQ-036 rst mid-write SHALL abandon the node; partially written words are not cleaned up.

Configuration
REQ-037 Macro LK_LIST_WRITER_CHECKSUM_EN: when defined, adds output sum [DATA_W-1:0], the modulo-2^DATA_W total of committed node values, updated at commit, cleared by rst/clr; when undefined, the port and its logic are absent and behaviour is otherwise identical.

Verification
REQ-038 Single node 5 with in_last -> writes (2,5),(3,0); head=2, node_cnt=1, done=1 two cycles after accept.
REQ-039 Nodes 1,2,3 with last on 3 -> writes (2,1),(3,0),(4,2),(5,0),(3,4),(6,3),(7,0),(5,6); sum=6 if checksum enabled.
REQ-040 MAX_NODES=2, three valid nodes without last -> third never accepted, full=1, in_ready=0, node_cnt=2.
REQ-041 clr asserted during PATCH -> commit completes, then node_cnt=0, head=0, done=0, in_ready=1.
REQ-042 rst asserted in WNXT -> all outputs at reset values in the same cycle, no further mem_we.
REQ-043 in_valid held with clr=1 in IDLE -> no accept, no mem_we.

Source files
------------

// File: rtl/lk_list_writer.sv
// rtl/lk_list_writer.sv - singly linked list builder writing nodes into word memory
//
// Purpose: accepts node values on a valid/ready handshake and appends each
// node to a singly linked list. Nodes are two words: value, then next pointer
// (0 terminates). The previous node's next pointer is patched after the new
// node is fully written, so the list is well formed after every commit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr                 synchronous restart (deferred to commit while busy)
//   in_valid/in_data/in_last/in_ready   node input handshake
//   mem_we/mem_addr/mem_wdata           write-only memory port
//   head, node_cnt      list head pointer (0 = empty), committed node count
//   busy, done, full    node write in progress, list terminated, capacity hit
//   sum                 only with LK_LIST_WRITER_CHECKSUM_EN: sum of committed values
//
// Optional feature macro: LK_LIST_WRITER_CHECKSUM_EN
module lk_list_writer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 2,
    parameter int MAX_NODES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W-1:0] node_cnt,
    output logic              busy,
    output logic              done,
`ifdef LK_LIST_WRITER_CHECKSUM_EN
    output logic [DATA_W-1:0] sum,
`endif
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] MAXN = ADDR_W'(MAX_NODES);

    typedef enum logic [2:0] {IDLE, WVAL, WNXT, PATCH, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   prev_q, prev_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic                last_q, last_d;
    logic                clr_pend_q, clr_pend_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= BASE;
            prev_q     <= '0;
            head_q     <= '0;
            cnt_q      <= '0;
            val_q      <= '0;
            last_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            last_q     <= last_d;
            clr_pend_q <= clr_pend_d;
            sum_q      <= sum_d;
        end
    end

    assign full     = (cnt_q == MAXN);
    assign busy     = (state_q == WVAL) || (state_q == WNXT) || (state_q == PATCH);
    assign done     = (state_q == DONE);
    // clr takes priority over a same-cycle handshake
    assign in_ready = (state_q == IDLE) && !full && !clr;
    assign head     = head_q;
    assign node_cnt = cnt_q;
`ifdef LK_LIST_WRITER_CHECKSUM_EN
    assign sum      = sum_q;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        head_d     = head_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        last_d     = last_q;
        clr_pend_d = clr_pend_q;
        sum_d      = sum_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    val_d   = in_data;
                    last_d  = in_last;
                    state_d = WVAL;
                end
            end
            WVAL: begin
                mem_we    = 1'b1;
                mem_addr  = cur_q;
                mem_wdata = val_q;
                state_d   = WNXT;
            end
            WNXT: begin
                // new node is terminated before it is linked in
                mem_we    = 1'b1;
                mem_addr  = cur_q + ADDR_W'(1);
                mem_wdata = '0;
                if (cnt_q != '0) state_d = PATCH;
                else             commit  = 1'b1;
            end
            PATCH: begin
                mem_we    = 1'b1;
                mem_addr  = prev_q + ADDR_W'(1);
                mem_wdata = DATA_W'(cur_q);
                commit    = 1'b1;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        if (busy && clr) clr_pend_d = 1'b1;

        if (commit) begin
            prev_d  = cur_q;
            cur_d   = cur_q + ADDR_W'(2);
            cnt_d   = cnt_q + ADDR_W'(1);
            sum_d   = sum_q + val_q;
            if (cnt_q == '0) head_d = BASE;
            state_d = last_q ? DONE : IDLE;
        end

        // restart: immediate when idle/done, otherwise on the commit edge
        if ((clr && !busy) || (commit && (clr_pend_q || clr))) begin
            state_d    = IDLE;
            cur_d      = BASE;
            prev_d     = '0;
            head_d     = '0;
            cnt_d      = '0;
            sum_d      = '0;
            clr_pend_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_lk_list_writer.sv
// tb/tb_lk_list_writer.sv - randomized self-checking bench for lk_list_writer
module tb_lk_list_writer;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int BASE = 2;
    localparam int MAXN = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready, mem_we, busy, done, full;
    logic [AW-1:0] mem_addr, head, node_cnt;
    logic [DW-1:0] mem_wdata;
`ifdef LK_LIST_WRITER_CHECKSUM_EN
    logic [DW-1:0] sum;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] tbmem [0:255];
    logic [DW-1:0] vals[$];
    logic [DW-1:0] exp_sum = '0;

    lk_list_writer #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .MAX_NODES(MAXN)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .head(head), .node_cnt(node_cnt), .busy(busy), .done(done),
`ifdef LK_LIST_WRITER_CHECKSUM_EN
        .sum(sum),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    // capture every memory write as seen on the clock edge that performs it
    always @(posedge clk) begin
        if (!rst && mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            tbmem[mem_addr] = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_list();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        vals.delete();
        exp_sum = '0;
        wa_q.delete();
        wd_q.delete();
        chk("clr_cnt", node_cnt, 0);
        chk("clr_head", head, 0);
        chk("clr_done", done, 0);
        chk("clr_ready", in_ready, 1);
    endtask

    // append one node and compare its writes, timing and status with the list rules
    task automatic push(input logic [DW-1:0] v, input bit last);
        int k;
        int i;
        int a;
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        i = vals.size();
        a = BASE + 2 * i;
        wa_q.delete();
        wd_q.delete();
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 50) chk("accept_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("busy_after_accept", busy, 1);
        k = 0;
        while (node_cnt == AW'(i) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("commit_latency", k, (i == 0) ? 2 : 3);
        vals.push_back(v);
        exp_sum += v;
        ea.push_back(AW'(a));     ed.push_back(v);
        ea.push_back(AW'(a + 1)); ed.push_back('0);
        if (i > 0) begin
            ea.push_back(AW'(a - 1)); ed.push_back(DW'(a));
        end
        chk("write_count", wa_q.size(), ea.size());
        for (int j = 0; j < ea.size() && j < wa_q.size(); j++) begin
            chk("write_addr", wa_q[j], ea[j]);
            chk("write_data", wd_q[j], ed[j]);
        end
        chk("node_cnt", node_cnt, vals.size());
        chk("head", head, BASE);
        chk("done", done, last);
        chk("busy_after_commit", busy, 0);
        chk("full", full, vals.size() == MAXN);
        chk("ready_after_commit", in_ready, !last && vals.size() < MAXN);
`ifdef LK_LIST_WRITER_CHECKSUM_EN
        chk("sum", sum, exp_sum);
`endif
    endtask

    // walk the captured memory image from head and compare with the accepted values
    task automatic traverse();
        logic [AW-1:0] p;
        p = head;
        foreach (vals[i]) begin
            chk("walk_value", tbmem[p], vals[i]);
            p = tbmem[p + 1][AW-1:0];
        end
        chk("walk_end", p, 0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] x;

        // reset state
        #12;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_head", head, 0);
        chk("rst_cnt", node_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);

        // single terminated node
        new_list();
        push(32'd5, 1'b1);
        traverse();
        // terminated list ignores further input
        wa_q.delete();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("done_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("done_no_write", wa_q.size(), 0);
        chk("done_held", done, 1);

        // three nodes 1,2,3
        new_list();
        push(32'd1, 1'b0);
        push(32'd2, 1'b0);
        push(32'd3, 1'b1);
        traverse();

        // random lists
        for (int r = 0; r < 6; r++) begin
            new_list();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push($urandom, j == n - 1);
            end
            traverse();
        end

        // fill to capacity, then offer more nodes
        new_list();
        for (int j = 0; j < MAXN; j++) push($urandom, 1'b0);
        wa_q.delete();
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("full_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("full_no_write", wa_q.size(), 0);
        chk("full_cnt", node_cnt, MAXN);
        chk("full_flag", full, 1);
        traverse();

        // clr during PATCH: commit finishes, then list restarts
        new_list();
        push($urandom, 1'b0);
        wa_q.delete();
        x = $urandom;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("patch_busy", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("patch_writes", wa_q.size(), 3);
        chk("patch_clr_cnt", node_cnt, 0);
        chk("patch_clr_head", head, 0);
        chk("patch_clr_done", done, 0);
        chk("patch_clr_ready", in_ready, 1);
        vals.delete();
        exp_sum = '0;

        // reset asserted in WNXT
        new_list();
        push($urandom, 1'b0);
        in_valid = 1'b1;
        in_data  = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", node_cnt, 0);
        chk("mid_rst_head", head, 0);
        @(negedge clk);
        rst = 1'b0;
        wa_q.delete();
        repeat (4) @(negedge clk);
        chk("mid_rst_no_write", wa_q.size(), 0);
        chk("mid_rst_ready", in_ready, 1);
        vals.delete();
        exp_sum = '0;

        // clr with in_valid in IDLE
        new_list();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("clr_valid_ready", in_ready, 0);
            @(negedge clk);
        end
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_valid_no_write", wa_q.size(), 0);
        chk("clr_valid_cnt", node_cnt, 0);

        // list still usable afterwards
        push(32'hA5A5_0001, 1'b0);
        push(32'hA5A5_0002, 1'b1);
        traverse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
